// File: rtl/uart_core_if.sv
// Byte-level handshake between uart_core (slave) and its client, the debug unit (master).
// tx_write is a request sampled every cycle and taken only when tx_busy is low; all strobes are one-cycle pulses.
interface uart_core_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       tx_write;
    logic [7:0] tx_data;
    logic       tx_finished;
    logic       tx_busy;

    modport master (
        output tx_write, tx_data,
        input  rx_ready, rx_data, rx_frame_err, tx_finished, tx_busy
    );

    modport slave (
        input  tx_write, tx_data,
        output rx_ready, rx_data, rx_frame_err, tx_finished, tx_busy
    );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: rx pin to byte strobes, byte writes to tx frames.
// Independent RX and TX state machines, each with a down-counting bit timer.
module uart_core #(
    parameter int CLK_FREQ  = 12000000,
    parameter int UART_FREQ = 115200
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              rx,
    output logic              tx,
    uart_core_if.slave        bus,
    output logic              dbg_rx_enable,
    output logic              dbg_tx_enable,
    output logic [2:0]        dbg_rx_state,
    output logic [1:0]        dbg_tx_state
);

    localparam int DIV = (CLK_FREQ + UART_FREQ / 2) / UART_FREQ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_core: bit period DIV must be at least 4 clocks");
        end
    endgenerate

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    // ---------------- RX ----------------
    rx_state_t     rx_state, rx_next;
    logic          rx_meta, rx_s;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_tick;

    assign rx_tick = (rx_cnt == '0);

    // Synchroniser presets high so leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) rx_state <= R_IDLE;
        else          rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:      if (!rx_s) rx_next = R_START;
            R_START:     if (rx_tick) rx_next = rx_s ? R_IDLE : R_DATA;
            R_DATA:      if (rx_tick && rx_bit == 3'd7) rx_next = R_STOP;
            R_STOP:      if (rx_tick) rx_next = rx_s ? R_IDLE : R_WAIT_HIGH;
            R_WAIT_HIGH: if (rx_s) rx_next = R_IDLE;
            default:     rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rx_cnt           <= '0;
            rx_bit           <= '0;
            rx_shift         <= '0;
            bus.rx_data      <= '0;
            bus.rx_ready     <= 1'b0;
            bus.rx_frame_err <= 1'b0;
        end else begin
            bus.rx_ready     <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            if (!rx_tick) rx_cnt <= rx_cnt - CNT_ONE;
            case (rx_state)
                // Idle keeps the half-bit delay armed so the start bit is sampled mid-bit.
                R_IDLE: begin
                    rx_cnt <= HALF_M1;
                    rx_bit <= '0;
                end
                R_START: if (rx_tick) rx_cnt <= DIV_M1;
                R_DATA: if (rx_tick) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                    rx_cnt   <= DIV_M1;
                end
                R_STOP: if (rx_tick) begin
                    if (rx_s) begin
                        bus.rx_data  <= rx_shift;
                        bus.rx_ready <= 1'b1;
                    end else begin
                        bus.rx_frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- TX ----------------
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_tick;

    assign tx_tick = (tx_cnt == '0);

    always_ff @(posedge clk) begin
        if (!n_reset) tx_state <= T_IDLE;
        else          tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (bus.tx_write) tx_next = T_START;
            T_START: if (tx_tick) tx_next = T_DATA;
            T_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = T_STOP;
            T_STOP:  if (tx_tick) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            tx              <= 1'b1;
            tx_cnt          <= '0;
            tx_bit          <= '0;
            tx_shift        <= '0;
            bus.tx_finished <= 1'b0;
        end else begin
            bus.tx_finished <= 1'b0;
            if (!tx_tick) tx_cnt <= tx_cnt - CNT_ONE;
            case (tx_state)
                T_IDLE: begin
                    tx     <= 1'b1;
                    tx_bit <= '0;
                    if (bus.tx_write) begin
                        tx_shift <= bus.tx_data;
                        tx       <= 1'b0;
                        tx_cnt   <= DIV_M1;
                    end
                end
                T_START: if (tx_tick) begin
                    tx       <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_cnt   <= DIV_M1;
                end
                T_DATA: if (tx_tick) begin
                    tx_cnt <= DIV_M1;
                    tx_bit <= tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx <= 1'b1;
                    end else begin
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end
                end
                // Finishing drops busy in the same cycle, so a write then starts the next frame at once.
                T_STOP: if (tx_tick) bus.tx_finished <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.tx_busy    = (tx_state != T_IDLE);
    assign dbg_tx_enable  = (tx_state != T_IDLE);
    assign dbg_rx_enable  = (rx_state != R_IDLE);
    assign dbg_rx_state   = rx_state;
    assign dbg_tx_state   = tx_state;

endmodule
